// File: rtl/ram_dma.sv
// ram_dma: single-channel memory copy/fill engine.
//
// Drives a synchronous RAM port (one-cycle registered read) while busy.
// Copy mode moves words one at a time through RD -> LAT -> WR.
// Fill mode writes a constant word on every cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle request, only sampled while idle
//   mode              0 = copy, 1 = fill (latched on start)
//   src_addr          copy source base (latched on start)
//   dst_addr          destination base (latched on start)
//   len               number of words (latched on start)
//   fill_data         fill value (latched on start)
//   abort             terminates an active transfer, no done pulse
//   busy              high while a transfer is in progress
//   done              one-cycle pulse after a completed transfer
//   mem_cs, mem_we    RAM chip select / write enable
//   mem_addr          RAM address
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data, valid the cycle after a read
module ram_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, LAT, WR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] srcPtr_q, srcPtr_d;
    logic [ADDR_WIDTH-1:0] dstPtr_q, dstPtr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] dataBuf_q, dataBuf_d;
    logic                  done_q, done_d;
    logic                  busy_q, memCs_q, memWe_q;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;

    // Next-state and datapath update. Abort wins over every other
    // transition outside IDLE, so the final write never pulses done if
    // abort arrives with it.
    always_comb begin
        state_d   = state_q;
        srcPtr_d  = srcPtr_q;
        dstPtr_d  = dstPtr_q;
        count_d   = count_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        dataBuf_d = dataBuf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    srcPtr_d = src_addr;
                    dstPtr_d = dst_addr;
                    count_d  = len;
                    mode_d   = mode;
                    fill_d   = fill_data;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = mode ? WR : RD;
                    end
                end
            end
            RD: begin
                state_d = abort ? IDLE : LAT;
            end
            LAT: begin
                // mem_cs is low here, so the RAM keeps presenting the word
                dataBuf_d = mem_rdata;
                state_d   = abort ? IDLE : WR;
            end
            WR: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    srcPtr_d = srcPtr_q + ADDR_WIDTH'(1);
                    dstPtr_d = dstPtr_q + ADDR_WIDTH'(1);
                    count_d  = count_q - LEN_WIDTH'(1);
                    if (count_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = mode_q ? WR : RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the state being
    // entered and the pointer values it will see. Address and data hold
    // their last value in states that do not drive the bus.
    always_comb begin
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        case (state_d)
            RD: begin
                memAddr_d = srcPtr_d;
            end
            WR: begin
                memAddr_d  = dstPtr_d;
                memWdata_d = mode_d ? fill_d : dataBuf_d;
            end
            default: begin
                memAddr_d = memAddr_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            srcPtr_q   <= '0;
            dstPtr_q   <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            fill_q     <= '0;
            dataBuf_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            memCs_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            srcPtr_q   <= srcPtr_d;
            dstPtr_q   <= dstPtr_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            fill_q     <= fill_d;
            dataBuf_q  <= dataBuf_d;
            done_q     <= done_d;
            busy_q     <= (state_d != IDLE);
            memCs_q    <= (state_d == RD) || (state_d == WR);
            memWe_q    <= (state_d == WR);
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_cs    = memCs_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: self-checking bench for ram_dma with a behavioural RAM and
// a word-level reference model of copy/fill transfers.
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [7:0]  fill_data = '0;
    logic        abort = 1'b0;
    logic        busy, done, mem_cs, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram      [0:65535];
    logic [7:0]  modelMem [0:65535];

    logic [15:0] wrAddr[$];
    logic [7:0]  wrData[$];
    logic [15:0] expAddr[$];
    logic [7:0]  expData[$];

    int checks = 0;
    int failures = 0;

    ram_dma #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len(len),
        .fill_data(fill_data),
        .abort(abort),
        .busy(busy),
        .done(done),
        .mem_cs(mem_cs),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle registered read, the DUT's target.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Bus monitor: logs every write cycle seen mid-cycle.
    always @(negedge clk) begin
        if (mem_cs && mem_we) begin
            wrAddr.push_back(mem_addr);
            wrData.push_back(mem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: performs the first nWords word moves in ascending
    // order on the model memory and records the expected write stream.
    task automatic modelApply(input logic m, input logic [15:0] s, input logic [15:0] d,
                              input int nWords, input logic [7:0] f);
        logic [15:0] a;
        logic [7:0]  v;
        expAddr.delete();
        expData.delete();
        for (int i = 0; i < nWords; i++) begin
            a = d + 16'(i);
            v = m ? f : modelMem[16'(s + 16'(i))];
            modelMem[a] = v;
            expAddr.push_back(a);
            expData.push_back(v);
        end
    endtask

    function automatic int memDiffs();
        int n = 0;
        for (int i = 0; i < 65536; i++) begin
            if (ram[i] !== modelMem[i]) n++;
        end
        return n;
    endfunction

    // Presents a request for one cycle starting at a falling edge.
    task automatic applyStimulus(input logic m, input logic [15:0] s, input logic [15:0] d,
                                 input logic [15:0] n, input logic [7:0] f);
        @(negedge clk);
        wrAddr.delete();
        wrData.delete();
        mode      = m;
        src_addr  = s;
        dst_addr  = d;
        len       = n;
        fill_data = f;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one transfer, watching every cycle after the start edge.
    // abortAt/pokeAt name the busy cycle in which abort or a second
    // start is raised (0 = never).
    task automatic runTransfer(input string tag, input logic m, input logic [15:0] s,
                               input logic [15:0] d, input logic [15:0] n,
                               input logic [7:0] f, input int abortAt, input int pokeAt);
        int total, expBusy, expWords, expDoneAt, limit;
        int busyCnt, doneAt, doneCnt, patternErr, dataErr, k;
        total    = m ? int'(n) : 3 * int'(n);
        expBusy  = (abortAt > 0) ? abortAt : total;
        expWords = (abortAt > 0) ? (m ? abortAt : abortAt / 3) : int'(n);
        expDoneAt = (abortAt > 0) ? 0 : total + 1;
        limit    = expBusy + 6;
        busyCnt = 0; doneAt = 0; doneCnt = 0; patternErr = 0; dataErr = 0;
        applyStimulus(m, s, d, n, f);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneAt == 0) doneAt = c;
            end
            if (busy) begin
                k = busyCnt;
                busyCnt++;
                if (m) begin
                    if (!(mem_cs && mem_we && mem_addr == d + 16'(k))) patternErr++;
                end else begin
                    case (k % 3)
                        0: if (!(mem_cs && !mem_we && mem_addr == s + 16'(k / 3))) patternErr++;
                        1: if (mem_cs) patternErr++;
                        default: if (!(mem_cs && mem_we && mem_addr == d + 16'(k / 3))) patternErr++;
                    endcase
                end
            end else if (mem_cs || mem_we) begin
                patternErr++;
            end
            abort = (c == abortAt);
            if (pokeAt > 0 && c == pokeAt) begin
                start     = 1'b1;
                mode      = ~m;
                dst_addr  = 16'($urandom);
                len       = 16'd1;
                fill_data = ~f;
            end else begin
                start = 1'b0;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        modelApply(m, s, d, expWords, f);
        checkOutput({tag, ".busyCycles"}, busyCnt, expBusy);
        checkOutput({tag, ".doneCycle"}, doneAt, expDoneAt);
        checkOutput({tag, ".doneCount"}, doneCnt, (abortAt > 0) ? 0 : 1);
        checkOutput({tag, ".pattern"}, patternErr, 0);
        checkOutput({tag, ".writeCount"}, wrAddr.size(), expAddr.size());
        if (wrAddr.size() == expAddr.size()) begin
            foreach (expAddr[i]) begin
                if (wrAddr[i] !== expAddr[i] || wrData[i] !== expData[i]) dataErr++;
            end
        end
        checkOutput({tag, ".writeData"}, dataErr, 0);
        checkOutput({tag, ".memory"}, memDiffs(), 0);
    endtask

    // Reset asserted in the middle of a fill: outputs must drop at once
    // and nothing more may be written once reset is released.
    task automatic resetMidFill();
        logic [15:0] d;
        d = 16'($urandom);
        applyStimulus(1'b1, 16'h0000, d, 16'd10, 8'h3C);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstMid.busy", busy, 1'b0);
        checkOutput("rstMid.cs", mem_cs, 1'b0);
        checkOutput("rstMid.we", mem_we, 1'b0);
        checkOutput("rstMid.done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        modelApply(1'b1, 16'h0000, d, 3, 8'h3C);
        checkOutput("rstMid.writeCount", wrAddr.size(), 3);
        checkOutput("rstMid.memory", memDiffs(), 0);
    endtask

    // Main sequence: reset, directed cases, then randomized transfers.
    initial begin
        logic [7:0]  v;
        logic        m;
        logic [15:0] s, d, n;
        int          ab;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            modelMem[i] = v;
        end

        #2 rst = 1'b1;
        #1;
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.cs", mem_cs, 1'b0);
        checkOutput("reset.we", mem_we, 1'b0);
        checkOutput("reset.addr", mem_addr, 16'h0000);
        checkOutput("reset.wdata", mem_wdata, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        runTransfer("fill", 1'b1, 16'h0000, 16'h0100, 16'd4, 8'hA5, 0, 0);

        ram[16'h0010] = 8'h11; modelMem[16'h0010] = 8'h11;
        ram[16'h0011] = 8'h22; modelMem[16'h0011] = 8'h22;
        ram[16'h0012] = 8'h33; modelMem[16'h0012] = 8'h33;
        runTransfer("copy", 1'b0, 16'h0010, 16'h0200, 16'd3, 8'h00, 0, 0);
        checkOutput("copy.readback", {ram[16'h0200], ram[16'h0201], ram[16'h0202]}, 24'h112233);

        runTransfer("wrap", 1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h5A, 0, 0);
        runTransfer("zeroLen", 1'b0, 16'h1234, 16'h4321, 16'd0, 8'h00, 0, 0);
        runTransfer("abort", 1'b0, 16'h0300, 16'h0400, 16'd8, 8'h00, 5, 0);
        runTransfer("afterAbort", 1'b1, 16'h0000, 16'h0500, 16'd2, 8'h77, 0, 0);
        runTransfer("overlap", 1'b0, 16'h0600, 16'h0602, 16'd6, 8'h00, 0, 0);
        runTransfer("startBusy", 1'b1, 16'h0000, 16'h0700, 16'd6, 8'hC3, 0, 2);
        resetMidFill();
        runTransfer("afterReset", 1'b0, 16'hFFFD, 16'h0800, 16'd5, 8'h00, 0, 0);

        for (int t = 0; t < 24; t++) begin
            m = 1'($urandom);
            s = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
            n = 16'($urandom_range(0, 12));
            v = 8'($urandom);
            ab = 0;
            if (n != 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(1, m ? int'(n) : 3 * int'(n));
            end
            runTransfer($sformatf("rand%0d", t), m, s, d, n, v, ab, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
